// File: rtl/nco_wave_gen_if.sv
// Sample-request, run-control, frequency-word handshake and code output
// bundle between the NCO and its PWM DAC / controller.
interface nco_wave_gen_if #(
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned CODE_WIDTH  = 10
);
  logic                   next_sample;
  logic                   enable;
  logic [1:0]             wave_sel;
  logic [PHASE_WIDTH-1:0] fcw_in;
  logic                   fcw_valid;
  logic                   fcw_ready;
  logic [CODE_WIDTH-1:0]  code;
  logic                   code_valid;

  modport master (
    output next_sample, enable, wave_sel, fcw_in, fcw_valid,
    input  fcw_ready, code, code_valid
  );

  modport slave (
    input  next_sample, enable, wave_sel, fcw_in, fcw_valid,
    output fcw_ready, code, code_valid
  );
endinterface

// File: rtl/nco_wave_gen.sv
// Numerically controlled oscillator producing sawtooth/square/triangle codes
// for a PWM DAC, with a one-deep pending frequency word promoted on samples.
module nco_wave_gen #(
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned CODE_WIDTH  = 10
) (
  input logic          clk,
  input logic          rst,
  nco_wave_gen_if.slave bus
);

  localparam logic [1:0] WAVE_SAW    = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;

  logic [PHASE_WIDTH-1:0] phase_q;
  logic [PHASE_WIDTH-1:0] fcw_act_q;
  logic [PHASE_WIDTH-1:0] fcw_pend_q;
  logic                   pend_q;
  logic                   ready_q;
  logic [CODE_WIDTH-1:0]  code_q;
  logic                   code_valid_q;

  logic [PHASE_WIDTH-1:0] incr_c;
  logic [CODE_WIDTH-1:0]  tri_c;
  logic [CODE_WIDTH-1:0]  wave_c;
  logic                   accept_c;
  logic                   pend_n_c;

  // Effective increment uses the pending word if present, before any new acceptance.
  always_comb begin
    incr_c   = pend_q ? fcw_pend_q : fcw_act_q;
    accept_c = bus.fcw_valid && ready_q;
    pend_n_c = pend_q;
    if (accept_c) begin
      pend_n_c = 1'b1;
    end else if (bus.next_sample) begin
      pend_n_c = 1'b0;
    end
  end

  // Waveform shaping from the current phase.
  always_comb begin
    tri_c  = phase_q[PHASE_WIDTH-2 -: CODE_WIDTH];
    wave_c = '0;
    case (bus.wave_sel)
      WAVE_SAW:    wave_c = phase_q[PHASE_WIDTH-1 -: CODE_WIDTH];
      WAVE_SQUARE: wave_c = phase_q[PHASE_WIDTH-1] ? '0 : '1;
      WAVE_TRI:    wave_c = phase_q[PHASE_WIDTH-1] ? ~tri_c : tri_c;
      default:     wave_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= '0;
      fcw_act_q    <= '0;
      fcw_pend_q   <= '0;
      pend_q       <= 1'b0;
      ready_q      <= 1'b0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
    end else begin
      code_valid_q <= bus.next_sample;
      pend_q       <= pend_n_c;
      ready_q      <= !pend_n_c;
      if (accept_c) begin
        fcw_pend_q <= bus.fcw_in;
      end
      if (bus.next_sample) begin
        if (pend_q) begin
          fcw_act_q <= fcw_pend_q;
        end
        if (bus.enable) begin
          code_q  <= wave_c;
          phase_q <= PHASE_WIDTH'(phase_q + incr_c);
        end else begin
          code_q  <= '0;
          phase_q <= '0;
        end
      end
    end
  end

  assign bus.fcw_ready  = ready_q;
  assign bus.code       = code_q;
  assign bus.code_valid = code_valid_q;

endmodule

// File: doc/nco_wave_gen.md
NCO_WAVE_GEN -- requirements
Module: nco_wave_gen

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 24, meaning phase accumulator and frequency control word width.
REQ-002 SHALL have parameter CODE_WIDTH, default 10, meaning output code width fed to the PWM DAC; CODE_WIDTH <= PHASE_WIDTH-1.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port next_sample  input  1  single-cycle request from DAC to produce the next sample.
REQ-006 SHALL have port enable  input  1  generator run control, sampled only on next_sample cycles.
REQ-007 SHALL have port wave_sel  input  2  waveform: 0 sawtooth, 1 square, 2 triangle, 3 silence; sampled only on next_sample cycles.
REQ-008 SHALL have port fcw_in  input  PHASE_WIDTH  new frequency control word.
REQ-009 SHALL have port fcw_valid  input  1  fcw_in offered.
REQ-010 SHALL have port fcw_ready  output  1  block can accept fcw_in.
REQ-011 SHALL have port code  output  CODE_WIDTH  registered sample code to DAC.
REQ-012 SHALL have port code_valid  output  1  one-cycle pulse when code updates.

Function
REQ-013 SHALL hold phase register P (PHASE_WIDTH), active word A, pending word R with pending flag F.
REQ-014 SHALL accept fcw_in into R and set F on a cycle with fcw_valid && fcw_ready; fcw_ready = !F && !rst-state.
REQ-015 SHALL define effective increment E = R if F else A, evaluated before any same-cycle acceptance.
REQ-016 On next_sample with enable=1: code <= f(P, wave_sel); P <= (P + E) mod 2^PHASE_WIDTH; if F then A <= R and F <= 0.
REQ-017 On next_sample with enable=0: code <= 0; P <= 0; pending promotion per REQ-016 still occurs.
REQ-018 A word accepted in the same cycle as next_sample SHALL NOT affect that sample; it becomes effective at the following next_sample.
REQ-019 code_valid SHALL be 1 exactly in the cycle after each next_sample cycle (latency 1), else 0.
REQ-020 code SHALL hold its value between next_sample events.
REQ-021 Sawtooth: f = P[PHASE_WIDTH-1 -: CODE_WIDTH].
REQ-022 Square: f = all ones if P[PHASE_WIDTH-1]==0, else 0.
REQ-023 Triangle: t = P[PHASE_WIDTH-2 -: CODE_WIDTH]; f = t if P MSB==0, else ~t.
REQ-024 Silence: f = 0; phase still advances.
REQ-025 Phase addition SHALL wrap modulo 2^PHASE_WIDTH with no saturation or overflow flag.
REQ-026 fcw_in/fcw_valid changes while fcw_ready=0 SHALL be ignored.

Reset
REQ-027 While rst=1: P=0, A=0, R=0, F=0, code=0, code_valid=0, fcw_ready=0.
REQ-028 First cycle after rst deasserts: fcw_ready=1; next_sample during rst SHALL be ignored.
REQ-029 rst mid-operation SHALL discard pending word and phase; no code_valid pulse from a next_sample coincident with rst.

Verification (PHASE_WIDTH=24, CODE_WIDTH=10)
REQ-030 Reset, load fcw 0x010000, enable=1, wave_sel=0, three next_sample pulses -> code 0, 4, 8, code_valid one cycle after each.
REQ-031 fcw 0x400000, wave_sel=1, four next_samples -> code 1023, 1023, 0, 0.
REQ-032 fcw 0x200000, wave_sel=2, six next_samples -> code 0, 256, 512, 768, 1023, 767.
REQ-033 fcw 0xFFFFFF, sawtooth, three next_samples -> code 0, 1023, 1023 (phase 0, 0xFFFFFF, 0xFFFFFE wrap).
REQ-034 Active fcw 0x010000; present 0x020000 in the same cycle as next_sample -> that sample increments by 0x010000, next by 0x020000; fcw_ready low until the promoting next_sample.
REQ-035 Mid-run enable=0 at next_sample -> code 0; then enable=1 -> restarts at code 0; separate rst mid-run with pending word -> all outputs 0, fcw_ready 0 during rst, 1 after, old pending not applied.
